// File: rtl/rob_commit_unit_if.sv
// Dispatcher, CDB and register-commit signals of the reorder buffer.
// The ROB takes the slave side; the surrounding pipeline (or a bench) takes the master side.
interface rob_commit_unit_if #(
  parameter int ROB_ID_W = 5
);
  logic                alloc_valid_from_dispatcher;
  logic [4:0]          alloc_rd_from_dispatcher;
  logic [31:0]         alloc_pc_from_dispatcher;
  logic                alloc_is_branch_from_dispatcher;
  logic                alloc_pred_taken_from_dispatcher;
  logic [ROB_ID_W-1:0] free_rob_id_to_dispatcher;
  logic                full_to_dispatcher;
  logic                cdb_valid;
  logic [ROB_ID_W-1:0] cdb_rob_id;
  logic [31:0]         cdb_value;
  logic                cdb_taken;
  logic [31:0]         cdb_target;
  logic [4:0]          rd_to_register;
  logic [31:0]         V_to_register;
  logic [ROB_ID_W-1:0] Q_to_register;
  logic                commit_flag_to_cdb;
  logic                rollback_flag_to_cdb;
  logic [31:0]         rollback_pc_to_fetcher;
  logic [31:0]         dbg_commit_pos;

  modport master (
    output alloc_valid_from_dispatcher, alloc_rd_from_dispatcher, alloc_pc_from_dispatcher,
           alloc_is_branch_from_dispatcher, alloc_pred_taken_from_dispatcher,
           cdb_valid, cdb_rob_id, cdb_value, cdb_taken, cdb_target,
    input  free_rob_id_to_dispatcher, full_to_dispatcher, rd_to_register, V_to_register,
           Q_to_register, commit_flag_to_cdb, rollback_flag_to_cdb, rollback_pc_to_fetcher,
           dbg_commit_pos
  );

  modport slave (
    input  alloc_valid_from_dispatcher, alloc_rd_from_dispatcher, alloc_pc_from_dispatcher,
           alloc_is_branch_from_dispatcher, alloc_pred_taken_from_dispatcher,
           cdb_valid, cdb_rob_id, cdb_value, cdb_taken, cdb_target,
    output free_rob_id_to_dispatcher, full_to_dispatcher, rd_to_register, V_to_register,
           Q_to_register, commit_flag_to_cdb, rollback_flag_to_cdb, rollback_pc_to_fetcher,
           dbg_commit_pos
  );
endinterface

// File: rtl/rob_commit_unit.sv
// In-order reorder buffer: allocates at tail, captures CDB results, retires the head in order.
// Optional ROB_COMMIT_TRACE_EN adds a commit counter and simulation trace of commits/rollbacks.
module rob_commit_unit #(
  parameter int ROB_SIZE = 16,
  parameter int ROB_ID_W = 5
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  rob_commit_unit_if.slave bus
);
  localparam int IDX_W = $clog2(ROB_SIZE);
  localparam int CNT_W = IDX_W + 1;

  logic [IDX_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ROB_SIZE-1:0] busy_q, busy_d, ready_q, ready_d;
  logic [ROB_SIZE-1:0] is_branch_q, is_branch_d, pred_taken_q, pred_taken_d, taken_q, taken_d;
  logic [4:0]          rd_q     [ROB_SIZE];
  logic [4:0]          rd_d     [ROB_SIZE];
  logic [31:0]         pc_q     [ROB_SIZE];
  logic [31:0]         pc_d     [ROB_SIZE];
  logic [31:0]         value_q  [ROB_SIZE];
  logic [31:0]         value_d  [ROB_SIZE];
  logic [31:0]         target_q [ROB_SIZE];
  logic [31:0]         target_d [ROB_SIZE];

  logic                commit_flag_q, commit_flag_d, rollback_flag_q, rollback_flag_d;
  logic [4:0]          commit_rd_q, commit_rd_d;
  logic [31:0]         commit_v_q, commit_v_d, commit_pc_q, commit_pc_d;
  logic [31:0]         rollback_pc_q, rollback_pc_d;
  logic [ROB_ID_W-1:0] commit_id_q, commit_id_d;

  logic                full, commit, mispredict, alloc_acc, cdb_hit;
  logic [IDX_W-1:0]    cdb_idx;

  assign full       = (count_q == CNT_W'(ROB_SIZE));
  assign commit     = (count_q != '0) && ready_q[head_q];
  assign mispredict = commit && is_branch_q[head_q] && (taken_q[head_q] != pred_taken_q[head_q]);
  assign alloc_acc  = bus.alloc_valid_from_dispatcher && !full && !mispredict;
  assign cdb_idx    = IDX_W'(bus.cdb_rob_id - ROB_ID_W'(1));
  assign cdb_hit    = bus.cdb_valid && (bus.cdb_rob_id != '0) &&
                      (bus.cdb_rob_id <= ROB_ID_W'(ROB_SIZE)) && busy_q[cdb_idx];

  always_comb begin
    head_d          = head_q;
    tail_d          = tail_q;
    busy_d          = busy_q;
    ready_d         = ready_q;
    is_branch_d     = is_branch_q;
    pred_taken_d    = pred_taken_q;
    taken_d         = taken_q;
    rd_d            = rd_q;
    pc_d            = pc_q;
    value_d         = value_q;
    target_d        = target_q;
    commit_flag_d   = commit;
    rollback_flag_d = mispredict;
    commit_rd_d     = '0;
    commit_v_d      = '0;
    commit_id_d     = '0;
    commit_pc_d     = commit_pc_q;
    rollback_pc_d   = rollback_pc_q;

    if (cdb_hit) begin
      ready_d[cdb_idx]  = 1'b1;
      value_d[cdb_idx]  = bus.cdb_value;
      taken_d[cdb_idx]  = bus.cdb_taken;
      target_d[cdb_idx] = bus.cdb_target;
    end

    if (alloc_acc) begin
      busy_d[tail_q]       = 1'b1;
      ready_d[tail_q]      = 1'b0;
      rd_d[tail_q]         = bus.alloc_rd_from_dispatcher;
      pc_d[tail_q]         = bus.alloc_pc_from_dispatcher;
      is_branch_d[tail_q]  = bus.alloc_is_branch_from_dispatcher;
      pred_taken_d[tail_q] = bus.alloc_pred_taken_from_dispatcher;
      tail_d               = tail_q + 1'b1;
    end

    if (commit) begin
      busy_d[head_q]  = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
      commit_rd_d     = rd_q[head_q];
      commit_v_d      = value_q[head_q];
      commit_id_d     = ROB_ID_W'(head_q) + ROB_ID_W'(1);
      commit_pc_d     = pc_q[head_q];
    end

    count_d = count_q + CNT_W'(alloc_acc) - CNT_W'(commit);

    // A mispredicted head flushes everything younger, winning over alloc and CDB capture.
    if (mispredict) begin
      rollback_pc_d = taken_q[head_q] ? target_q[head_q] : pc_q[head_q] + 32'd4;
      busy_d        = '0;
      ready_d       = '0;
      head_d        = '0;
      tail_d        = '0;
      count_d       = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      busy_q          <= '0;
      ready_q         <= '0;
      commit_flag_q   <= 1'b0;
      rollback_flag_q <= 1'b0;
      commit_rd_q     <= '0;
      commit_v_q      <= '0;
      commit_id_q     <= '0;
      commit_pc_q     <= '0;
      rollback_pc_q   <= '0;
    end else if (rdy_in) begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      busy_q          <= busy_d;
      ready_q         <= ready_d;
      commit_flag_q   <= commit_flag_d;
      rollback_flag_q <= rollback_flag_d;
      commit_rd_q     <= commit_rd_d;
      commit_v_q      <= commit_v_d;
      commit_id_q     <= commit_id_d;
      commit_pc_q     <= commit_pc_d;
      rollback_pc_q   <= rollback_pc_d;
    end else begin
      commit_flag_q   <= 1'b0;
      rollback_flag_q <= 1'b0;
    end
  end

  // Entry payload needs no reset: busy/ready gate every use of it.
  always_ff @(posedge clk_in) begin
    if (rst_in && rdy_in) begin
      is_branch_q  <= is_branch_d;
      pred_taken_q <= pred_taken_d;
      taken_q      <= taken_d;
      rd_q         <= rd_d;
      pc_q         <= pc_d;
      value_q      <= value_d;
      target_q     <= target_d;
    end
  end

  assign bus.free_rob_id_to_dispatcher = ROB_ID_W'(tail_q) + ROB_ID_W'(1);
  assign bus.full_to_dispatcher        = full;
  assign bus.commit_flag_to_cdb        = commit_flag_q & rdy_in;
  assign bus.rollback_flag_to_cdb      = rollback_flag_q & rdy_in;
  assign bus.rd_to_register            = commit_rd_q;
  assign bus.V_to_register             = commit_v_q;
  assign bus.Q_to_register             = commit_id_q;
  assign bus.rollback_pc_to_fetcher    = rollback_pc_q;
  assign bus.dbg_commit_pos            = commit_pc_q;

`ifdef ROB_COMMIT_TRACE_EN
  logic [31:0] commit_cnt_q;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      commit_cnt_q <= '0;
    end else if (rdy_in && commit) begin
      commit_cnt_q <= commit_cnt_q + 32'd1;
      $display("rob commit #%0d pc=%08h rd=%0d value=%08h",
               commit_cnt_q + 32'd1, pc_q[head_q], rd_q[head_q], value_q[head_q]);
      if (mispredict) begin
        $display("rob rollback redirect pc=%08h", rollback_pc_d);
      end
    end
  end
`endif
endmodule
